// File: rtl/rv32i_uart_tx_pkg.sv
// rv32i_uart_tx_pkg: register offsets, TX FSM states and STATUS packing for the UART transmitter
package rv32i_uart_tx_pkg;
  localparam logic [1:0] UART_TXDATA_OFF = 2'd0;
  localparam logic [1:0] UART_STATUS_OFF = 2'd1;
  localparam logic [1:0] UART_CTRL_OFF   = 2'd2;

  typedef enum logic [1:0] {UTX_IDLE, UTX_START, UTX_DATA, UTX_STOP} uart_tx_state_e;

  function automatic logic [31:0] uart_status_word(input logic full, input logic empty,
                                                   input logic active, input logic ovf,
                                                   input logic [4:0] cnt);
    return {23'd0, cnt, ovf, active, empty, full};
  endfunction
endpackage

// File: rtl/rv32i_uart_tx_sync_fifo.sv
// sync_fifo: first-word-through FIFO; drops pushes when full, flush beats push and pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rp];
  // pointers and occupancy; flush empties the FIFO at the edge
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(do_push);
      rp    <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage, written only by accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/rv32i_uart_tx.sv
// rv32i_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO on the core's store bus
module rv32i_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_be,
  input  logic        bus_we,
  output logic [31:0] bus_rdata,
  output logic        txd,
  output logic        irq
);
  import rv32i_uart_tx_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
  uart_tx_state_e state;
  logic [BW-1:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] shift, dout;
  logic [CW-1:0] count;
  logic sel, wr, push, pop, flush, ctrl_wr, ovf_clr, full, empty;
  logic tx_en, irq_en, overflow, tx_active, bit_end;
  logic [1:0] off;
  logic [31:0] status;
  logic unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:8], bus_be[3:1]};
  assign sel       = bus_addr[31:4] == BASE_ADDR[31:4];
  assign off       = bus_addr[3:2];
  assign wr        = bus_we & sel;
  assign push      = wr & (off == UART_TXDATA_OFF) & bus_be[0];
  assign ctrl_wr   = wr & (off == UART_CTRL_OFF) & bus_be[0];
  assign flush     = ctrl_wr & bus_wdata[1];
  assign ovf_clr   = wr & (off == UART_STATUS_OFF) & bus_wdata[3];
  assign tx_active = state != UTX_IDLE;
  assign bit_end   = baud == '0;
  assign pop       = tx_en & ~empty & ~flush & ((state == UTX_IDLE) | ((state == UTX_STOP) & bit_end));
  assign status    = uart_status_word(full, empty, tx_active, overflow, 5'(count));
  assign irq       = irq_en & empty & ~tx_active;
  assign bus_rdata = !sel ? 32'd0 :
                     off == UART_STATUS_OFF ? status :
                     off == UART_CTRL_OFF ? {29'd0, irq_en, 1'b0, tx_en} : 32'd0;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .din     (bus_wdata[7:0]),
    .dout    (dout),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // CTRL bits and sticky overflow; a same-cycle set beats the clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_en    <= 1'b1;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        tx_en  <= bus_wdata[0];
        irq_en <= bus_wdata[2];
      end
      overflow <= (push & full) | (overflow & ~ovf_clr);
    end
  end

  // TX FSM with baud counter; txd is registered from the current state so it trails the state by a cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= UTX_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      txd <= state == UTX_START ? 1'b0 : state == UTX_DATA ? shift[0] : 1'b1;
      case (state)
        UTX_IDLE:
          if (pop) begin
            shift   <= dout;
            bit_idx <= '0;
            baud    <= BAUD_LOAD;
            state   <= UTX_START;
          end
        UTX_START:
          if (bit_end) begin
            baud  <= BAUD_LOAD;
            state <= UTX_DATA;
          end else baud <= baud - BW'(1);
        UTX_DATA:
          if (bit_end) begin
            baud    <= BAUD_LOAD;
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
            state   <= bit_idx == 3'd7 ? UTX_STOP : UTX_DATA;
          end else baud <= baud - BW'(1);
        UTX_STOP:
          if (bit_end) begin
            if (pop) begin
              shift   <= dout;
              bit_idx <= '0;
              baud    <= BAUD_LOAD;
              state   <= UTX_START;
            end else state <= UTX_IDLE;
          end else baud <= baud - BW'(1);
        default: state <= UTX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32i_uart_tx.sv
// tb_rv32i_uart_tx: scoreboard bench decoding txd frames against bytes written to TXDATA
module tb_rv32i_uart_tx;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int CPB = 4;
  logic clk = 0, reset_n = 0;
  logic [31:0] bus_addr = 0, bus_wdata = 0, bus_rdata;
  logic [3:0] bus_be = 0;
  logic bus_we = 0, txd, irq;
  int cyc = 0, n_chk = 0, n_fail = 0, frames = 0;
  int starts[$];
  logic [7:0] sb[$];
  bit ignore = 0;

  rv32i_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_we(bus_we), .bus_rdata(bus_rdata), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic bus_wr(input logic [1:0] off, input logic [31:0] d, input logic [3:0] be, output int w);
    @(negedge clk);
    bus_addr = BASE | {28'd0, off, 2'b00};
    bus_wdata = d;
    bus_be = be;
    bus_we = 1;
    @(posedge clk);
    #1;
    w = cyc;
    bus_we = 0;
    bus_be = 0;
    bus_addr = 0;
  endtask

  task automatic send(input logic [7:0] b, output int w);
    sb.push_back(b);
    bus_wr(2'd0, {24'd0, b}, 4'h1, w);
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] d);
    bus_addr = addr;
    bus_we = 0;
    #1;
    d = bus_rdata;
    bus_addr = 0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(BASE | {28'd0, off, 2'b00}, d);
    check(tag, d, exp);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames < n && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("frame_count", frames, n);
  endtask

  // txd monitor: samples mid-bit and compares each decoded byte with the scoreboard head
  initial begin
    logic [7:0] b;
    logic s0, sp;
    int sc;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && txd === 1'b0) begin
        sc = cyc;
        repeat (CPB / 2) @(negedge clk);
        s0 = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        sp = txd;
        if (!ignore) begin
          check("start_bit", s0, 0);
          check("stop_bit", sp, 1);
          if (sb.size() == 0) check("extra_frame", {24'd0, b}, 32'h100);
          else check("rx_byte", b, sb.pop_front());
          starts.push_back(sc);
          frames++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, w2, f0, s1, s2;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", txd, 1);
    check("rst_irq", irq, 0);
    rd_chk("rst_status", 2'd1, 32'h002);
    rd_chk("rst_ctrl", 2'd2, 32'h001);
    rd_chk("txdata_rd0", 2'd0, 32'h0);
    rd_chk("off3_rd0", 2'd3, 32'h0);
    begin
      logic [31:0] d;
      bus_rd(BASE + 32'h14, d);
      check("unsel_rd0", d, 32'h0);
    end
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;

    // 1: single byte latency and frame length
    f0 = frames;
    send(8'h55, w);
    wait_until(w + 1);
    rd_chk("t1_popped", 2'd1, 32'h006);
    wait_until(w + 40);
    rd_chk("t1_active_end", 2'd1, 32'h006);
    wait_until(w + 41);
    rd_chk("t1_idle", 2'd1, 32'h002);
    wait_frames(f0 + 1);
    check("t1_start_lat", starts[$] - w, 2);

    // 2: fill with tx disabled, overflow, then drain and clear overflow
    bus_wr(2'd2, 32'h0, 4'h1, w);
    f0 = frames;
    for (int i = 0; i < 16; i++) send(8'(i * 17 + 3), w);
    bus_wr(2'd0, 32'hEE, 4'h1, w);
    rd_chk("t2_full", 2'd1, 32'h109);
    wait_until(w + 20);
    check("t2_no_tx", frames, f0);
    bus_wr(2'd2, 32'h1, 4'h1, w);
    wait_frames(f0 + 16);
    wait_until(cyc + 5);
    rd_chk("t2_drained", 2'd1, 32'h00A);
    check("t2_sb_empty", sb.size(), 0);
    bus_wr(2'd1, 32'h8, 4'hF, w);
    rd_chk("t2_ovf_clr", 2'd1, 32'h002);
    bus_wr(2'd0, 32'h77, 4'h2, w);
    wait_until(w + 2);
    rd_chk("be_gate", 2'd1, 32'h002);

    // 3: back-to-back frames with no gap
    f0 = frames;
    send(8'hA5, w);
    send(8'h3C, w2);
    wait_until(w + 80);
    rd_chk("t3_active", 2'd1, 32'h006);
    wait_until(w + 81);
    rd_chk("t3_idle", 2'd1, 32'h002);
    wait_frames(f0 + 2);
    s1 = starts[$-1];
    s2 = starts[$];
    check("t3_first_lat", s1 - w, 2);
    check("t3_gap", s2 - s1, 10 * CPB);

    // 4: flush during bit 3 of the first frame
    f0 = frames;
    send(8'h11, w);
    send(8'h22, w2);
    send(8'h33, w2);
    send(8'h44, w2);
    wait_until(w + 3);
    rd_chk("t4_count3", 2'd1, 32'h034);
    wait_until(w + 17);
    bus_wr(2'd2, 32'h3, 4'h1, w2);
    repeat (3) void'(sb.pop_back());
    rd_chk("t4_flushed", 2'd1, 32'h006);
    rd_chk("t4_ctrl", 2'd2, 32'h001);
    wait_frames(f0 + 1);
    wait_until(cyc + 60);
    check("t4_one_frame", frames, f0 + 1);
    rd_chk("t4_idle", 2'd1, 32'h002);

    // 5: reset in the middle of the data bits
    bus_wr(2'd2, 32'h5, 4'h1, w);
    f0 = frames;
    send(8'hC3, w);
    wait_until(w + 10);
    ignore = 1;
    sb.delete();
    @(negedge clk);
    reset_n = 0;
    @(posedge clk);
    #1;
    check("t5_txd", txd, 1);
    check("t5_irq", irq, 0);
    rd_chk("t5_status", 2'd1, 32'h002);
    rd_chk("t5_ctrl", 2'd2, 32'h001);
    @(negedge clk);
    reset_n = 1;
    wait_until(cyc + 60);
    ignore = 0;
    check("t5_no_frame", frames, f0);
    check("t5_txd_idle", txd, 1);

    // 6: irq follows empty and idle
    bus_wr(2'd2, 32'h5, 4'h1, w);
    check("t6_irq_idle", irq, 1);
    f0 = frames;
    send(8'h81, w);
    check("t6_irq_push", irq, 0);
    wait_until(w + 20);
    check("t6_irq_mid", irq, 0);
    wait_until(w + 40);
    check("t6_irq_stop", irq, 0);
    wait_until(w + 41);
    check("t6_irq_done", irq, 1);
    wait_frames(f0 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
